// File: rtl/program_sequencer.sv
// program_sequencer: program counter plus hardware call/return stack.
// Each enabled cycle it picks the next fetch address with the priority
// ret > call > taken jump > pc+1. All outputs come straight from registers.
module program_sequencer #(
    parameter int                ADDR_W      = 8,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
    localparam int               DEPTH_W     = $clog2(STACK_DEPTH + 1),
    localparam int               IDX_W       = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               jump,
    input  logic [1:0]         j_mode,
    input  logic               call,
    input  logic               ret,
    input  logic [ADDR_W-1:0]  target,
    input  logic               zero_flag,
    input  logic               carry_flag,
    output logic [ADDR_W-1:0]  pc,
    output logic [DEPTH_W-1:0] depth,
    output logic               stack_ovf,
    output logic               stack_unf
);

    // Branch condition selects carried in j_mode.
    localparam logic [1:0] JM_ALWAYS  = 2'b00;
    localparam logic [1:0] JM_ZERO    = 2'b01;
    localparam logic [1:0] JM_CARRY   = 2'b10;
    localparam logic [1:0] JM_NONZERO = 2'b11;

    logic [ADDR_W-1:0]  r_pc;
    logic [DEPTH_W-1:0] r_depth;
    logic               r_stack_ovf;
    logic               r_stack_unf;
    logic [ADDR_W-1:0]  r_stack [STACK_DEPTH];

    logic [ADDR_W-1:0]  w_pc_inc;
    logic               w_full;
    logic               w_empty;
    logic [DEPTH_W-1:0] w_depth_m1;
    logic [IDX_W-1:0]   w_push_idx;
    logic [IDX_W-1:0]   w_pop_idx;
    logic               w_jump_taken;

    // pc+1 wraps naturally at ADDR_W bits, so a call at all-ones pushes 0.
    assign w_pc_inc   = r_pc + 1'b1;
    assign w_full     = (r_depth == DEPTH_W'(STACK_DEPTH));
    assign w_empty    = (r_depth == '0);
    assign w_depth_m1 = r_depth - 1'b1;
    // Index slices are only used when the matching full/empty guard allows it.
    assign w_push_idx = r_depth[IDX_W-1:0];
    assign w_pop_idx  = w_depth_m1[IDX_W-1:0];

    // Decode whether a plain jump's condition holds this cycle.
    always_comb begin
        // NOTE: default first so every path assigns the output and no latch is inferred.
        w_jump_taken = 1'b0;
        case (j_mode)
            JM_ALWAYS:  w_jump_taken = 1'b1;
            JM_ZERO:    w_jump_taken = zero_flag;
            JM_CARRY:   w_jump_taken = carry_flag;
            JM_NONZERO: w_jump_taken = ~zero_flag;
            default:    w_jump_taken = 1'b0;
        endcase
    end

    // Advance pc, stack and sticky error flags on each enabled edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc        <= RESET_VEC;
            r_depth     <= '0;
            r_stack_ovf <= 1'b0;
            r_stack_unf <= 1'b0;
            // NOTE: the return stack is small and must read as zero after reset, so it is cleared
            // here; large RAM-style memories would normally be left without reset.
            for (int i = 0; i < STACK_DEPTH; i++) begin
                r_stack[i] <= '0;
            end
        end else if (en) begin
            // NOTE: non-blocking assignments keep every register reading its pre-edge value.
            if (ret) begin
                // Return wins over call and jump; a call in the same cycle is dropped.
                if (!w_empty) begin
                    r_pc    <= r_stack[w_pop_idx];
                    r_depth <= w_depth_m1;
                end else begin
                    r_stack_unf <= 1'b1;
                    r_pc        <= w_pc_inc;
                end
            end else if (call) begin
                // Calls are unconditional; on a full stack the return address is lost.
                if (!w_full) begin
                    r_stack[w_push_idx] <= w_pc_inc;
                    r_depth             <= r_depth + 1'b1;
                end else begin
                    r_stack_ovf <= 1'b1;
                end
                r_pc <= target;
            end else if (jump && w_jump_taken) begin
                r_pc <= target;
            end else begin
                r_pc <= w_pc_inc;
            end
        end
    end

    assign pc        = r_pc;
    assign depth     = r_depth;
    assign stack_ovf = r_stack_ovf;
    assign stack_unf = r_stack_unf;

endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: directed scenarios followed by random traffic, all
// compared against a queue-based reference model of the sequencer.
module tb_program_sequencer;

    localparam int ADDR_W      = 8;
    localparam int STACK_DEPTH = 4;
    localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              jump;
    logic [1:0]        j_mode;
    logic              call;
    logic              ret;
    logic [ADDR_W-1:0] target;
    logic              zero_flag;
    logic              carry_flag;
    logic [ADDR_W-1:0] pc;
    logic [DEPTH_W-1:0] depth;
    logic              stack_ovf;
    logic              stack_unf;

    int checks = 0;
    int errors = 0;

    // Reference model state: pc as an integer, stack as a queue (back = top).
    int model_pc  = 0;
    int model_stk[$];
    bit model_ovf = 1'b0;
    bit model_unf = 1'b0;

    program_sequencer #(
        .ADDR_W     (ADDR_W),
        .STACK_DEPTH(STACK_DEPTH),
        .RESET_VEC  (8'h00)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .jump      (jump),
        .j_mode    (j_mode),
        .call      (call),
        .ret       (ret),
        .target    (target),
        .zero_flag (zero_flag),
        .carry_flag(carry_flag),
        .pc        (pc),
        .depth     (depth),
        .stack_ovf (stack_ovf),
        .stack_unf (stack_unf)
    );

    always #5 clk = ~clk;

    // Compare one observed value against a value the bench computed itself.
    task automatic check_val(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Compare all outputs with the reference model.
    task automatic check_model(input string tag);
        check_val({tag, " pc"},    int'(pc),        model_pc);
        check_val({tag, " depth"}, int'(depth),     model_stk.size());
        check_val({tag, " ovf"},   int'(stack_ovf), int'(model_ovf));
        check_val({tag, " unf"},   int'(stack_unf), int'(model_unf));
    endtask

    // Reference model: one clock edge worth of sequencer behaviour.
    task automatic model_edge();
        bit cond;
        if (!rst_n) begin
            model_pc = 0;
            model_stk.delete();
            model_ovf = 1'b0;
            model_unf = 1'b0;
        end else if (en) begin
            if (ret) begin
                if (model_stk.size() > 0) begin
                    model_pc = model_stk.pop_back();
                end else begin
                    model_unf = 1'b1;
                    model_pc  = (model_pc + 1) % 256;
                end
            end else if (call) begin
                if (model_stk.size() < STACK_DEPTH) model_stk.push_back((model_pc + 1) % 256);
                else                                model_ovf = 1'b1;
                model_pc = int'(target);
            end else begin
                case (j_mode)
                    2'd0:    cond = 1'b1;
                    2'd1:    cond = zero_flag;
                    2'd2:    cond = carry_flag;
                    default: cond = !zero_flag;
                endcase
                model_pc = (jump && cond) ? int'(target) : (model_pc + 1) % 256;
            end
        end
    endtask

    // Drive one cycle of inputs, advance model and DUT, then compare.
    task automatic step(input logic r, input logic e, input logic j, input logic [1:0] m,
                        input logic c, input logic rt, input logic [7:0] t,
                        input logic z, input logic cy, input string tag);
        rst_n = r; en = e; jump = j; j_mode = m; call = c; ret = rt;
        target = t; zero_flag = z; carry_flag = cy;
        model_edge();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    // Unconditional jump used to position pc for a scenario.
    task automatic goto(input logic [7:0] t);
        step(1, 1, 1, 2'b00, 0, 0, t, 0, 0, "goto");
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; jump = 1'b0; j_mode = 2'b00; call = 1'b0;
        ret = 1'b0; target = '0; zero_flag = 1'b0; carry_flag = 1'b0;

        // Reset for two cycles, then three plain sequential cycles.
        step(0, 0, 0, 2'b00, 0, 0, 8'h00, 0, 0, "reset0");
        step(0, 1, 1, 2'b00, 1, 0, 8'h55, 0, 0, "reset1");
        check_val("reset pc", int'(pc), 0);
        check_val("reset depth", int'(depth), 0);
        for (int i = 1; i <= 3; i++) begin
            step(1, 1, 0, 2'b00, 0, 0, 8'h00, 0, 0, "seq");
            check_val("seq pc", int'(pc), i);
        end

        // Conditional jumps.
        goto(8'h05);
        step(1, 1, 1, 2'b01, 0, 0, 8'h40, 0, 0, "jz not taken");
        check_val("jz not taken pc", int'(pc), 8'h06);
        step(1, 1, 1, 2'b01, 0, 0, 8'h40, 1, 0, "jz taken");
        check_val("jz taken pc", int'(pc), 8'h40);
        step(1, 1, 1, 2'b11, 0, 0, 8'h70, 0, 0, "jnz taken");
        check_val("jnz taken pc", int'(pc), 8'h70);
        step(1, 1, 1, 2'b11, 0, 0, 8'h90, 1, 0, "jnz not taken");
        step(1, 1, 1, 2'b10, 0, 0, 8'h90, 0, 0, "jc not taken");
        step(1, 1, 1, 2'b10, 0, 0, 8'h90, 0, 1, "jc taken");
        check_val("jc taken pc", int'(pc), 8'h90);

        // Nested call/return; call ignores a false j_mode condition.
        goto(8'h10);
        step(1, 1, 1, 2'b01, 1, 0, 8'h80, 0, 0, "call1");
        step(1, 1, 0, 2'b00, 1, 0, 8'hC0, 0, 0, "call2");
        check_val("nested depth", int'(depth), 2);
        check_val("nested pc", int'(pc), 8'hC0);
        step(1, 1, 1, 2'b00, 0, 1, 8'h22, 0, 0, "ret1");
        check_val("ret1 pc", int'(pc), 8'h81);
        step(1, 1, 0, 2'b00, 0, 1, 8'h00, 0, 0, "ret2");
        check_val("ret2 pc", int'(pc), 8'h11);
        check_val("ret2 depth", int'(depth), 0);

        // Overflow then underflow.
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0, 2'b00, 1, 0, 8'(8'hA0 + i), 0, 0, "ovf call");
        end
        check_val("ovf depth", int'(depth), 4);
        check_val("ovf flag", int'(stack_ovf), 1);
        check_val("ovf pc", int'(pc), 8'hA4);
        step(1, 1, 0, 2'b00, 0, 1, 8'h00, 0, 0, "pop"); check_val("pop1", int'(pc), 8'hA3);
        step(1, 1, 0, 2'b00, 0, 1, 8'h00, 0, 0, "pop"); check_val("pop2", int'(pc), 8'hA2);
        step(1, 1, 0, 2'b00, 0, 1, 8'h00, 0, 0, "pop"); check_val("pop3", int'(pc), 8'hA1);
        step(1, 1, 0, 2'b00, 0, 1, 8'h00, 0, 0, "pop"); check_val("pop4", int'(pc), 8'h12);
        step(1, 1, 0, 2'b00, 0, 1, 8'h00, 0, 0, "unf ret");
        check_val("unf flag", int'(stack_unf), 1);
        check_val("unf pc", int'(pc), 8'h13);
        check_val("unf depth", int'(depth), 0);

        // Wrap at all-ones, enable hold, return to 0.
        goto(8'hFF);
        step(1, 1, 0, 2'b00, 1, 0, 8'h20, 0, 0, "wrap call");
        check_val("wrap call pc", int'(pc), 8'h20);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1, 2'b00, 1, 0, 8'h77, 0, 0, "en hold");
        end
        check_val("hold depth", int'(depth), 1);
        step(1, 1, 0, 2'b00, 0, 1, 8'h00, 0, 0, "wrap ret");
        check_val("wrap ret pc", int'(pc), 8'h00);
        check_val("sticky ovf", int'(stack_ovf), 1);

        // Simultaneous call+ret, then reset mid-call.
        goto(8'h32);
        step(1, 1, 0, 2'b00, 1, 0, 8'h50, 0, 0, "push 33");
        step(1, 1, 1, 2'b00, 1, 1, 8'h60, 0, 0, "call+ret");
        check_val("call+ret pc", int'(pc), 8'h33);
        check_val("call+ret depth", int'(depth), 0);
        step(0, 1, 0, 2'b00, 1, 0, 8'h60, 0, 0, "reset mid-call");
        check_val("mid reset pc", int'(pc), 0);
        check_val("mid reset ovf", int'(stack_ovf), 0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) >= 2), ($urandom_range(0, 99) < 80),
                 1'($urandom), 2'($urandom), ($urandom_range(0, 99) < 25),
                 ($urandom_range(0, 99) < 25), 8'($urandom), 1'($urandom),
                 1'($urandom), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
